regfile_access_ctrl: RTL
========================

# regfile_access_ctrl

Initiator side of the register-file port. Accepts operand-fetch requests from decode and writeback requests from the retire stage, serialises them onto the single-ported register file (one-hot read/write enable, select, write value; read data returns a fixed number of cycles later), and presents both operands with a valid/ready handshake. It sits between decode/writeback and `regfile`, and is the only block that drives `regfile`'s request inputs.

## Interface

Parameters:

- `WIDTH`, default 32: data width. Register select width is `$clog2(WIDTH)`, which is 5 at the default.
- `RD_LATENCY`, default 2: number of cycles from the cycle a read is driven to the cycle its `rf_r_out` is valid. Must be at least 1.

Ports (one clock; reset is asynchronous and active-low):

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1; `req_ready` out 1: operand-fetch handshake.
- `req_rs1`, `req_rs2` in `$clog2(WIDTH)`: source register indices.
- `req_use_rs1`, `req_use_rs2` in 1: operand needed.
- `opnd_valid` out 1; `opnd_ready` in 1: operand-result handshake.
- `opnd_rs1_val`, `opnd_rs2_val` out `WIDTH`: fetched operands.
- `wb_valid` in 1; `wb_ready` out 1: writeback handshake.
- `wb_rd` in `$clog2(WIDTH)`; `wb_data` in `WIDTH`: writeback target and value.
- `rf_r_enable`, `rf_w_enable` out 1: register-file request enables. Never both high in the same cycle.
- `rf_r_select`, `rf_w_select` out `$clog2(WIDTH)`; `rf_w_val` out `WIDTH`: register-file request fields.
- `rf_r_out` in `WIDTH`: read data from the register file.

## Operation

FSM states: `IDLE`, `WRITE`, `ISSUE_RS1`, `ISSUE_RS2`, `DRAIN`, `HOLD`.

- **Handshake readiness.** `wb_ready` is 1 only in `IDLE`. `req_ready` is 1 only in `IDLE` when `wb_valid` is 0. Writeback therefore has strict priority.
- **IDLE + wb accepted → WRITE.** In `WRITE`, drive `rf_w_enable`=1, `rf_w_select`=`wb_rd`, `rf_w_val`=`wb_data` for exactly one cycle, then return to `IDLE`. If `wb_rd`=0, the request is still accepted and still spends the one `WRITE` cycle, but `rf_w_enable` stays 0.
- **IDLE + req accepted.** A source whose use flag is 0, or whose index is 0, is "skipped" and its operand value is 0.
  - Go to `ISSUE_RS1` if rs1 is not skipped.
  - Otherwise go to `ISSUE_RS2` if rs2 is not skipped.
  - Otherwise go to `HOLD` with both operands 0.
- **ISSUE_RS1 / ISSUE_RS2.** Drive `rf_r_enable`=1 and `rf_r_select`=rs for exactly one cycle. Push a tag {valid, which} into a shift register of depth `RD_LATENCY`. Transitions:
  - `ISSUE_RS1` → `ISSUE_RS2` if rs2 is not skipped, else → `DRAIN`.
  - `ISSUE_RS2` → `DRAIN`.
- **Capture.** At the end of each cycle where the tag at the shift-register output is valid, load `rf_r_out` into the matching operand register.
- **DRAIN → HOLD** in the cycle after the last valid tag is captured.
- **HOLD.** `opnd_valid`=1 with operands stable. When `opnd_valid` and `opnd_ready` are both high at an edge, go to `IDLE`.
- **Register-file outputs.** All `rf_*` outputs are registered. In any state that does not drive a request, both enables are 0 and select/value are held at 0.
- **Reset.** `rst_n` low immediately (asynchronously) clears the FSM to `IDLE`, all outputs to 0, operand registers to 0 and all tags to invalid. Any in-flight read is abandoned. `rst_n` must be held low for at least `RD_LATENCY` edges so the register file's request pipeline flushes.

## Timing

Let cycle t be the accept edge's cycle (`req_valid && req_ready`). With L = `RD_LATENCY`:

- Both operands read: `ISSUE_RS1` in t+1, `ISSUE_RS2` in t+2; captures at the end of t+1+L and t+2+L; `opnd_valid` from t+3+L (t+5 at L=2).
- One operand read: issue in t+1; `opnd_valid` from t+2+L.
- No operand read: `opnd_valid` from t+1.
- Writeback accepted in t: `rf_w_enable` high in t+1; `IDLE` in t+2. A read driven in t+2 or later returns the new value.
- Maximum issue rate: one request per cycle on the register-file port. There is no overlap between separate fetches.
- Output values after reset: `req_ready`=1 once `rst_n` is high (if `wb_valid`=0); `wb_ready`=1; every other output is 0.

## Structure

- Package `riscv_rf_pkg` holds:
  - the FSM state enum `rf_ctrl_state_t`;
  - `REG_IDX_W` = `$clog2(32)`;
  - `REG_X0` = 0;
  - tag struct `rd_tag_t` {valid, which}.
- Sub-module `rf_rd_tag_pipe`: parameterised `RD_LATENCY`-deep shift register of `rd_tag_t`, with async active-low reset. The FSM and capture logic stay in `regfile_access_ctrl`.

## Test plan

Each line is stimulus → required response. The bench instantiates `regfile` as the responder.

- **Write then read.** wb rd=5 data=0xDEADBEEF; then req rs1=5, use_rs1=1, use_rs2=0 → exactly one `rf_r_enable` pulse; `opnd_rs1_val`=0xDEADBEEF, `opnd_rs2_val`=0; `opnd_valid` at t+4.
- **Two-operand fetch.** Preload x1=0x11, x2=0x22; req rs1=1 rs2=2 → `rf_r_select` 1 then 2 on consecutive cycles; `opnd_valid` first high exactly at t+5 with 0x11/0x22.
- **Simultaneous requests.** `wb_valid` (rd=7, data=0x77) and `req_valid` (rs1=7) both high in `IDLE` → `req_ready`=0 that cycle; write issued first; `opnd_rs1_val`=0x77.
- **x0 handling.** wb rd=0 data=0xFFFF → `wb_ready` handshake completes, `rf_w_enable` never pulses. Then req rs1=0 rs2=0 use both → no `rf_r_enable`; `opnd_valid` at t+1 with 0/0.
- **Backpressure.** Hold `opnd_ready`=0 for 10 cycles in `HOLD` → `opnd_valid`=1 and values constant; `req_ready`=`wb_ready`=0 throughout. The handshake completes on the first cycle `opnd_ready`=1.
- **Reset mid-operation.** Pull `rst_n` low during `ISSUE_RS2` → all outputs 0 immediately, with no clock edge needed. After 3 edges, release reset → `req_ready`=1, no stale `opnd_valid`; the next fetch returns correct values.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller and its
// read-tag pipeline.
package riscv_rf_pkg;

    localparam int unsigned REG_IDX_W = $clog2(32);
    localparam int unsigned REG_X0    = 0;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        ISSUE_RS1,
        ISSUE_RS2,
        DRAIN,
        HOLD
    } rf_ctrl_state_t;

    // which: 0 = read belongs to rs1, 1 = read belongs to rs2
    typedef struct packed {
        logic valid;
        logic which;
    } rd_tag_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Bundle of the decode, writeback, operand and register-file request signals.
// master = the access controller, slave = its surroundings.
interface regfile_access_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SEL_W = $clog2(WIDTH);

    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_rs1;
    logic [SEL_W-1:0] req_rs2;
    logic             req_use_rs1;
    logic             req_use_rs2;

    logic             opnd_valid;
    logic             opnd_ready;
    logic [WIDTH-1:0] opnd_rs1_val;
    logic [WIDTH-1:0] opnd_rs2_val;

    logic             wb_valid;
    logic             wb_ready;
    logic [SEL_W-1:0] wb_rd;
    logic [WIDTH-1:0] wb_data;

    logic             rf_r_enable;
    logic             rf_w_enable;
    logic [SEL_W-1:0] rf_r_select;
    logic [SEL_W-1:0] rf_w_select;
    logic [WIDTH-1:0] rf_w_val;
    logic [WIDTH-1:0] rf_r_out;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_use_rs1, req_use_rs2,
        output req_ready,
        output opnd_valid, opnd_rs1_val, opnd_rs2_val,
        input  opnd_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rf_r_enable, rf_w_enable, rf_r_select, rf_w_select, rf_w_val,
        input  rf_r_out
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_use_rs1, req_use_rs2,
        input  req_ready,
        input  opnd_valid, opnd_rs1_val, opnd_rs2_val,
        output opnd_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rf_r_enable, rf_w_enable, rf_r_select, rf_w_select, rf_w_val,
        output rf_r_out
    );

endinterface

// File: rtl/regfile_access_ctrl_tag_pipe.sv
// RD_LATENCY-deep shift register of read tags; the output stage lines up with
// the cycle the register file presents the matching read data.
module rf_rd_tag_pipe
    import riscv_rf_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t [RD_LATENCY-1:0] r_stage;

    if (RD_LATENCY == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stage <= '0;
            end else begin
                r_stage[0] <= i_tag;
            end
        end
    end else begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stage <= '0;
            end else begin
                r_stage <= {r_stage[RD_LATENCY-2:0], i_tag};
            end
        end
    end

    assign o_tag = r_stage[RD_LATENCY-1];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: serialises writebacks and operand fetches
// onto a single-ported register file with a fixed read latency.
module regfile_access_ctrl
    import riscv_rf_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_LATENCY = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_access_ctrl_if.master bus
);

    localparam int unsigned      SEL_W  = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] SEL_X0 = SEL_W'(REG_X0);

    rf_ctrl_state_t   r_state;
    rf_ctrl_state_t   w_next;

    logic [SEL_W-1:0] r_rs2;
    logic             r_need_rs2;
    logic [WIDTH-1:0] r_opnd_rs1;
    logic [WIDTH-1:0] r_opnd_rs2;

    logic             r_rf_r_enable;
    logic             r_rf_w_enable;
    logic [SEL_W-1:0] r_rf_r_select;
    logic [SEL_W-1:0] r_rf_w_select;
    logic [WIDTH-1:0] r_rf_w_val;

    logic             w_rf_r_enable;
    logic             w_rf_w_enable;
    logic [SEL_W-1:0] w_rf_r_select;
    logic [SEL_W-1:0] w_rf_w_select;
    logic [WIDTH-1:0] w_rf_w_val;

    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_req_acc;
    logic             w_wb_ready;
    logic             w_req_ready;
    logic             w_opnd_valid;
    logic             w_last_captured;

    rd_tag_t          w_tag_push;
    rd_tag_t          w_tag_out;

    assign w_rs1_used = bus.req_use_rs1 && (bus.req_rs1 != SEL_X0);
    assign w_rs2_used = bus.req_use_rs2 && (bus.req_rs2 != SEL_X0);
    assign w_req_acc  = (r_state == IDLE) && bus.req_valid && !bus.wb_valid;

    // rs1 is always issued before rs2, so the final capture is the rs2 tag
    // whenever rs2 was read, otherwise the rs1 tag.
    assign w_last_captured = w_tag_out.valid && (w_tag_out.which == r_need_rs2);

    always_comb begin
        w_tag_push       = '0;
        w_tag_push.valid = r_rf_r_enable;
        w_tag_push.which = (r_state == ISSUE_RS2);
    end

    rf_rd_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_push),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.wb_valid) begin
                    w_next = WRITE;
                end else if (bus.req_valid) begin
                    if (w_rs1_used) begin
                        w_next = ISSUE_RS1;
                    end else if (w_rs2_used) begin
                        w_next = ISSUE_RS2;
                    end else begin
                        w_next = HOLD;
                    end
                end
            end
            WRITE:     w_next = IDLE;
            ISSUE_RS1: w_next = r_need_rs2 ? ISSUE_RS2 : DRAIN;
            ISSUE_RS2: w_next = DRAIN;
            DRAIN:     if (w_last_captured) w_next = HOLD;
            HOLD:      if (bus.opnd_ready) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Register-file request fields are derived from the state being entered
    // so they can be registered and line up with that state's cycle.
    always_comb begin
        w_wb_ready    = rst_n && (r_state == IDLE);
        w_req_ready   = w_wb_ready && !bus.wb_valid;
        w_opnd_valid  = (r_state == HOLD);
        w_rf_r_enable = 1'b0;
        w_rf_r_select = '0;
        w_rf_w_enable = 1'b0;
        w_rf_w_select = '0;
        w_rf_w_val    = '0;
        case (w_next)
            WRITE: begin
                if (bus.wb_rd != SEL_X0) begin
                    w_rf_w_enable = 1'b1;
                    w_rf_w_select = bus.wb_rd;
                    w_rf_w_val    = bus.wb_data;
                end
            end
            ISSUE_RS1: begin
                w_rf_r_enable = 1'b1;
                w_rf_r_select = bus.req_rs1;
            end
            ISSUE_RS2: begin
                w_rf_r_enable = 1'b1;
                w_rf_r_select = (r_state == IDLE) ? bus.req_rs2 : r_rs2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_r_enable <= 1'b0;
            r_rf_w_enable <= 1'b0;
            r_rf_r_select <= '0;
            r_rf_w_select <= '0;
            r_rf_w_val    <= '0;
            r_rs2         <= '0;
            r_need_rs2    <= 1'b0;
            r_opnd_rs1    <= '0;
            r_opnd_rs2    <= '0;
        end else begin
            r_rf_r_enable <= w_rf_r_enable;
            r_rf_w_enable <= w_rf_w_enable;
            r_rf_r_select <= w_rf_r_select;
            r_rf_w_select <= w_rf_w_select;
            r_rf_w_val    <= w_rf_w_val;
            if (w_req_acc) begin
                r_rs2      <= bus.req_rs2;
                r_need_rs2 <= w_rs2_used;
                r_opnd_rs1 <= '0;
                r_opnd_rs2 <= '0;
            end else if (w_tag_out.valid) begin
                if (w_tag_out.which) begin
                    r_opnd_rs2 <= bus.rf_r_out;
                end else begin
                    r_opnd_rs1 <= bus.rf_r_out;
                end
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.wb_ready     = w_wb_ready;
    assign bus.opnd_valid   = w_opnd_valid;
    assign bus.opnd_rs1_val = r_opnd_rs1;
    assign bus.opnd_rs2_val = r_opnd_rs2;
    assign bus.rf_r_enable  = r_rf_r_enable;
    assign bus.rf_w_enable  = r_rf_w_enable;
    assign bus.rf_r_select  = r_rf_r_select;
    assign bus.rf_w_select  = r_rf_w_select;
    assign bus.rf_w_val     = r_rf_w_val;

endmodule
